udp_tx: RTL and testbench

UDP_TX -- requirements
Module: udp_tx

---
 rtl/udp_pkg.sv | 36 +++
 rtl/udp_tx.sv | 168 ++++++++++++++++
 tb/tb_udp_tx.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/udp_pkg.sv
// Shared UDP transmit definitions: header length, FSM encoding, default
// port/payload limits and the header byte selector.
package udp_pkg;

  localparam logic [15:0] UDP_HDR_LEN         = 16'd8;
  localparam logic [15:0] DEFAULT_LOCAL_PORT  = 16'hF000;
  localparam logic [15:0] DEFAULT_MAX_PAYLOAD = 16'd1472;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_ACK  = 3'd1,
    SEND_HEAD = 3'd2,
    SEND_DATA = 3'd3,
    TX_END    = 3'd4
  } udp_state_t;

  // Checksum bytes are sent as zero: checksum generation is disabled.
  function automatic logic [7:0] hdr_byte(input logic [2:0]  idx,
                                          input logic [15:0] src,
                                          input logic [15:0] dst,
                                          input logic [15:0] len);
    logic [7:0] b;
    b = 8'h00;
    case (idx)
      3'd0: b = src[15:8];
      3'd1: b = src[7:0];
      3'd2: b = dst[15:8];
      3'd3: b = dst[7:0];
      3'd4: b = len[15:8];
      3'd5: b = len[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/udp_tx.sv
// UDP transmit framer: requests the IP layer, then streams the 8-byte header
// followed by payload bytes pulled from the application buffer.
//
// state     | meaning
// IDLE      | waiting for an application request
// WAIT_ACK  | udp_tx_req held high until the IP layer grants
// SEND_HEAD | emitting header bytes 0..7
// SEND_DATA | emitting payload bytes
// TX_END    | end pulse visible, busy released on exit
module udp_tx
  import udp_pkg::*;
#(
  parameter logic [15:0] LOCAL_PORT  = DEFAULT_LOCAL_PORT,
  parameter logic [15:0] MAX_PAYLOAD = DEFAULT_MAX_PAYLOAD
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        app_tx_req,
  input  logic [15:0] app_tx_length,
  input  logic [15:0] app_dest_port,
  output logic        app_tx_rd_en,
  input  logic [7:0]  app_tx_data,
  output logic        app_tx_busy,
  output logic        udp_tx_req,
  input  logic        ip_tx_ack,
  output logic [15:0] udp_tx_length,
  output logic [7:0]  udp_tx_data,
  output logic        udp_tx_valid,
  output logic        udp_tx_end,
  output logic        udp_tx_error
);

  // Read strobe leads the output byte by two cycles: buffer latency plus output register.
  localparam logic [15:0] RD_LEAD = 16'd2;

  udp_state_t  state_q, state_n;
  logic [15:0] cnt_q, cnt_n;
  logic [15:0] dest_q, dest_n;
  logic [15:0] length_q, length_n;
  logic [7:0]  data_q, data_n;
  logic        valid_q, valid_n;
  logic        rd_en_q, rd_en_n;
  logic        busy_q, busy_n;
  logic        req_q, req_n;
  logic        end_q, end_n;
  logic        err_q, err_n;
  logic [7:0]  hdr;
  logic        rd_due;

  assign hdr    = hdr_byte(cnt_q[2:0], LOCAL_PORT, dest_q, length_q);
  // cnt_q is the index of the byte emitted at the coming edge.
  assign rd_due = (cnt_q >= (UDP_HDR_LEN - RD_LEAD)) && ((cnt_q + RD_LEAD) < length_q);

  always_comb begin
    state_n  = state_q;
    cnt_n    = cnt_q;
    dest_n   = dest_q;
    length_n = length_q;
    data_n   = 8'h00;
    valid_n  = 1'b0;
    rd_en_n  = 1'b0;
    busy_n   = busy_q;
    req_n    = req_q;
    end_n    = 1'b0;
    err_n    = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_n = 16'd0;
        if (app_tx_req) begin
          if (app_tx_length <= MAX_PAYLOAD) begin
            dest_n   = app_dest_port;
            length_n = app_tx_length + UDP_HDR_LEN;
            req_n    = 1'b1;
            busy_n   = 1'b1;
            state_n  = WAIT_ACK;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      WAIT_ACK: begin
        cnt_n = 16'd0;
        if (ip_tx_ack) begin
          req_n   = 1'b0;
          valid_n = 1'b1;
          data_n  = hdr;
          cnt_n   = 16'd1;
          state_n = SEND_HEAD;
        end
      end
      SEND_HEAD: begin
        if (cnt_q < UDP_HDR_LEN) begin
          valid_n = 1'b1;
          data_n  = hdr;
          cnt_n   = cnt_q + 16'd1;
          rd_en_n = rd_due;
          if ((cnt_q == UDP_HDR_LEN - 16'd1) && (length_q != UDP_HDR_LEN))
            state_n = SEND_DATA;
        end else begin
          end_n   = 1'b1;
          cnt_n   = 16'd0;
          state_n = TX_END;
        end
      end
      SEND_DATA: begin
        if (cnt_q < length_q) begin
          valid_n = 1'b1;
          data_n  = app_tx_data;
          cnt_n   = cnt_q + 16'd1;
          rd_en_n = rd_due;
        end else begin
          end_n   = 1'b1;
          cnt_n   = 16'd0;
          state_n = TX_END;
        end
      end
      TX_END: begin
        cnt_n   = 16'd0;
        busy_n  = 1'b0;
        state_n = IDLE;
      end
      default: begin
        cnt_n   = 16'd0;
        busy_n  = 1'b0;
        req_n   = 1'b0;
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q  <= IDLE;
      cnt_q    <= 16'd0;
      dest_q   <= 16'd0;
      length_q <= 16'd0;
      data_q   <= 8'h00;
      valid_q  <= 1'b0;
      rd_en_q  <= 1'b0;
      busy_q   <= 1'b0;
      req_q    <= 1'b0;
      end_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_n;
      cnt_q    <= cnt_n;
      dest_q   <= dest_n;
      length_q <= length_n;
      data_q   <= data_n;
      valid_q  <= valid_n;
      rd_en_q  <= rd_en_n;
      busy_q   <= busy_n;
      req_q    <= req_n;
      end_q    <= end_n;
      err_q    <= err_n;
    end
  end

  assign app_tx_rd_en  = rd_en_q;
  assign app_tx_busy   = busy_q;
  assign udp_tx_req    = req_q;
  assign udp_tx_length = length_q;
  assign udp_tx_data   = data_q;
  assign udp_tx_valid  = valid_q;
  assign udp_tx_end    = end_q;
  assign udp_tx_error  = err_q;

endmodule

// File: tb/tb_udp_tx.sv
// Scoreboard bench for udp_tx: directed datagrams push expected bytes, a
// negedge monitor pops and compares every valid byte.
module tb_udp_tx;
  import udp_pkg::*;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        app_tx_req = 1'b0;
  logic [15:0] app_tx_length = 16'd0;
  logic [15:0] app_dest_port = 16'd0;
  logic        app_tx_rd_en;
  logic [7:0]  app_tx_data = 8'h00;
  logic        app_tx_busy;
  logic        udp_tx_req;
  logic        ip_tx_ack = 1'b0;
  logic [15:0] udp_tx_length;
  logic [7:0]  udp_tx_data;
  logic        udp_tx_valid;
  logic        udp_tx_end;
  logic        udp_tx_error;

  udp_tx dut (
    .clk(clk), .rstn(rstn),
    .app_tx_req(app_tx_req), .app_tx_length(app_tx_length), .app_dest_port(app_dest_port),
    .app_tx_rd_en(app_tx_rd_en), .app_tx_data(app_tx_data), .app_tx_busy(app_tx_busy),
    .udp_tx_req(udp_tx_req), .ip_tx_ack(ip_tx_ack), .udp_tx_length(udp_tx_length),
    .udp_tx_data(udp_tx_data), .udp_tx_valid(udp_tx_valid), .udp_tx_end(udp_tx_end),
    .udp_tx_error(udp_tx_error)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  pay[0:1471];
  int          ptr = 0;
  int          rd_cnt = 0;
  int          exp_rd = 0;
  int          exp_run = 0;
  int          run = 0;
  int          valid_total = 0;
  int          end_cnt = 0;
  int          err_cnt = 0;
  int          req_cyc = 0;
  logic [15:0] exp_len = 16'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic expired(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  // Application buffer: byte appears the cycle after each read strobe.
  initial forever begin
    @(negedge clk);
    if (app_tx_rd_en) begin
      rd_cnt++;
      @(posedge clk);
      #1;
      app_tx_data = (ptr < 1472) ? pay[ptr] : 8'h00;
      ptr++;
    end
  end

  // Monitor: pops the scoreboard on every valid byte, checks framing at end.
  initial forever begin
    @(negedge clk);
    if (udp_tx_valid) begin
      run++;
      valid_total++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_byte: got %0h, expected none", udp_tx_data);
      end else begin
        check("byte", {24'd0, udp_tx_data}, {24'd0, exp_q.pop_front()});
      end
      check("tx_length", {16'd0, udp_tx_length}, {16'd0, exp_len});
    end else begin
      if (udp_tx_end) begin
        end_cnt++;
        check("run_len", run, exp_run);
        check("rd_count", rd_cnt, exp_rd);
        check("q_empty", exp_q.size(), 0);
      end
      run = 0;
    end
    if (udp_tx_error) err_cnt++;
    if (udp_tx_req) req_cyc++;
  end

  task automatic send(input logic [15:0] dest, input int len, input int ack_dly);
    logic [15:0] tot;
    tot = 16'(len) + 16'd8;
    exp_q.push_back(8'hF0); exp_q.push_back(8'h00);
    exp_q.push_back(dest[15:8]); exp_q.push_back(dest[7:0]);
    exp_q.push_back(tot[15:8]); exp_q.push_back(tot[7:0]);
    exp_q.push_back(8'h00); exp_q.push_back(8'h00);
    for (int i = 0; i < len; i++) exp_q.push_back(pay[i]);
    exp_len = tot;
    exp_run = len + 8;
    exp_rd  = len;
    rd_cnt  = 0;
    ptr     = 0;
    @(posedge clk); #1;
    app_tx_req = 1'b1; app_tx_length = 16'(len); app_dest_port = dest;
    @(posedge clk); #1;
    app_tx_req = 1'b0;
    check("req_asserted", {31'd0, udp_tx_req}, 32'd1);
    check("busy_asserted", {31'd0, app_tx_busy}, 32'd1);
    check("req_length", {16'd0, udp_tx_length}, {16'd0, tot});
    repeat (ack_dly) begin @(posedge clk); #1; end
    check("req_held", {31'd0, udp_tx_req}, 32'd1);
    ip_tx_ack = 1'b1;
    @(posedge clk); #1;
    ip_tx_ack = 1'b0;
    check("req_dropped", {31'd0, udp_tx_req}, 32'd0);
    check("first_valid", {31'd0, udp_tx_valid}, 32'd1);
  endtask

  task automatic wait_end(input string name, input int budget);
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!udp_tx_end && t < budget);
    if (!udp_tx_end) expired(name);
  endtask

  task automatic check_all_zero(input string name);
    check(name, {app_tx_rd_en, app_tx_busy, udp_tx_req, udp_tx_valid, udp_tx_end,
                 udp_tx_error, udp_tx_data, udp_tx_length}, 32'd0);
  endtask

  initial begin
    int snap_e, snap_r, snap_v, snap_rd;
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int snap_e, snap_r, snap_v, snap_rd;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset_state");
    rstn = 1'b1;

    // Payload 4, dest 1234, ack after 3 cycles.
    pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33; pay[3] = 8'h44;
    snap_e = end_cnt;
    send(16'h1234, 4, 3);
    wait_end("end_p4", 100);
    #1;
    check("end_count_p4", end_cnt - snap_e, 1);

    // Payload 0: header only.
    snap_e = end_cnt;
    send(16'h5678, 0, 1);
    wait_end("end_p0", 100);
    #1;
    check("end_count_p0", end_cnt - snap_e, 1);

    // Oversize request rejected.
    snap_r = req_cyc; snap_e = err_cnt;
    @(posedge clk); #1;
    app_tx_req = 1'b1; app_tx_length = 16'd1473; app_dest_port = 16'hAAAA;
    @(posedge clk); #1;
    app_tx_req = 1'b0;
    check("error_pulse", {31'd0, udp_tx_error}, 32'd1);
    check("busy_on_error", {31'd0, app_tx_busy}, 32'd0);
    repeat (5) begin @(posedge clk); #1; end
    check("error_count", err_cnt - snap_e, 1);
    check("req_on_error", req_cyc - snap_r, 0);

    // Maximum payload.
    for (int i = 0; i < 1472; i++) pay[i] = 8'(i * 7 + 3);
    snap_e = end_cnt;
    send(16'hBEEF, 1472, 2);
    check("max_length", {16'd0, udp_tx_length}, 32'h05C8);
    wait_end("end_max", 2000);
    #1;
    check("end_count_max", end_cnt - snap_e, 1);

    // Reset while payload byte 2 of 10 is on the output.
    for (int i = 0; i < 10; i++) pay[i] = 8'(8'hA0 + i);
    send(16'h0102, 10, 1);
    repeat (10) @(posedge clk);
    @(negedge clk);
    rstn = 1'b0;
    @(posedge clk); #1;
    check_all_zero("mid_reset_zero");
    exp_q.delete();
    @(posedge clk); #1;
    rstn = 1'b1;
    snap_v = valid_total; snap_rd = rd_cnt; snap_e = end_cnt;
    repeat (10) begin @(posedge clk); #1; end
    check("quiet_valid", valid_total - snap_v, 0);
    check("quiet_rd", rd_cnt - snap_rd, 0);
    check("quiet_end", end_cnt - snap_e, 0);
    for (int i = 0; i < 10; i++) pay[i] = 8'(8'h5A ^ (i * 13));
    send(16'h0304, 10, 1);
    wait_end("end_after_reset", 200);
    #1;
    check("end_count_after_reset", end_cnt - snap_e, 1);

    // Request during SEND_DATA ignored; request right after end accepted.
    for (int i = 0; i < 6; i++) pay[i] = 8'(8'hC0 + i);
    snap_e = end_cnt;
    send(16'h7777, 6, 2);
    repeat (8) @(posedge clk);
    #1;
    app_tx_req = 1'b1; app_tx_length = 16'd3; app_dest_port = 16'h9999;
    @(posedge clk); #1;
    app_tx_req = 1'b0;
    wait_end("end_b2b_first", 100);
    pay[0] = 8'hD1; pay[1] = 8'hD2; pay[2] = 8'hD3;
    send(16'h0BAD, 3, 0);
    wait_end("end_b2b_second", 100);
    repeat (4) begin @(posedge clk); #1; end
    check("end_count_b2b", end_cnt - snap_e, 2);
    check("busy_idle", {31'd0, app_tx_busy}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
